// File: rtl/serial_add_controller_if.sv
// Handshake and operand/result bundle between the input logic (master)
// and the bit-serial add controller (slave).
interface serial_add_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_controller.sv
// Bit-serial adder: one shared full-adder cell walks two WIDTH-bit operands
// LSB first, one bit per clock, with a start/busy/done handshake.
module oneBitAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic C
);
  assign Y = A ^ B ^ Cin;
  assign C = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_add_controller_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic             y_s;
  logic             c_s;
  logic [WIDTH-1:0] sum_sh_s;

  oneBitAdder u_fa (
    .A   (a_sh_r[0]),
    .B   (b_sh_r[0]),
    .Cin (carry_r),
    .Y   (y_s),
    .C   (c_s)
  );

  // Next value of the sum shift register: this cycle's Y enters at the MSB.
  always_comb begin
    sum_sh_s          = sum_sh_r >> 1'b1;
    sum_sh_s[WIDTH-1] = y_s;
  end

  // Sequencer, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      sum_sh_r   <= '0;
      carry_r    <= 1'b0;
      cnt_r      <= '0;
      sum_r      <= '0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            carry_r  <= bus.cin;
            cnt_r    <= '0;
            sum_sh_r <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_sh_r <= sum_sh_s;
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          carry_r  <= c_s;
          cnt_r    <= cnt_r + CW'(1);
          // carry_r is the carry into the MSB on the final bit
          if (cnt_r == LAST_BIT) begin
            sum_r      <= sum_sh_s;
            cout_r     <= c_s;
            overflow_r <= carry_r ^ c_s;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = overflow_r;
endmodule
